// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM state
// encoding, datapath select codes and the per-state control word.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTER = 4'd7,
      S_EXECUTEI = 4'd8,
      S_ALUWB    = 4'd9,
      S_JAL      = 4'd10,
      S_BEQ      = 4'd11,
      S_HALT     = 4'd12
   } state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_t;

   // Moore control word for each state; IDLE and unknown encodings give all zeros.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALURESULT;
            c.pc_update  = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
            c.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_update  = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_RS2;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
         end
         S_HALT: begin
            c.halted = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields to the 3-bit ALUControl code.
module riscv_alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   // Only R-type (op[5]=1) with funct7b5 set subtracts; addi never does.
   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000: begin
                  if (op5_i && funct7b5_i) alu_control_o = ALU_SUB;
                  else                     alu_control_o = ALU_ADD;
               end
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I main sequencer (Moore FSM with registered control word).
// Optional MEM_READY_EN adds a MemReady handshake stalling FETCH/MEMREAD/MEMWRITE.
module riscv_mc_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit EN_BNE       = 1'b1,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
`ifdef MEM_READY_EN
   input  logic       MemReady,
`endif
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       Halted
);

   state_e     state_q, state_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic [2:0] alu_control_q, alu_control_d;
   logic       mem_ready_s;
   logic       fetch_gate_s;
   logic       bne_s;

`ifdef MEM_READY_EN
   assign mem_ready_s = MemReady;
`else
   assign mem_ready_s = 1'b1;
`endif

   // Next-state logic; memory-facing states wait on the handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready_s) state_d = S_DECODE;
            else             state_d = S_FETCH;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BR:        state_d = S_BEQ;
               default: begin
                  if (ILLEGAL_HALT) state_d = S_HALT;
                  else              state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            if (op == OP_SW) state_d = S_MEMWRITE;
            else             state_d = S_MEMREAD;
         end
         S_MEMREAD: begin
            if (mem_ready_s) state_d = S_MEMWB;
            else             state_d = S_MEMREAD;
         end
         S_MEMWB: state_d = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready_s) state_d = S_FETCH;
            else             state_d = S_MEMWRITE;
         end
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_IDLE;
      endcase
   end

   assign ctrl_d = state_ctrl(state_d);

   riscv_alu_decoder u_alu_dec (
      .alu_op_i      (ctrl_d.alu_op),
      .funct3_i      (funct3),
      .op5_i         (op[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (alu_control_d)
   );

   // State and control word registered together so outputs never glitch on state decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ctrl_q        <= '0;
         alu_control_q <= 3'b000;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         alu_control_q <= alu_control_d;
      end
   end

   // FETCH strobes fire only in the cycle the memory accepts the access.
   assign fetch_gate_s = (state_q == S_FETCH) ? mem_ready_s : 1'b1;
   assign bne_s        = EN_BNE & (funct3 == 3'b001);

   assign PCWrite    = (ctrl_q.pc_update & fetch_gate_s) | (ctrl_q.branch & (Zero ^ bne_s));
   assign IRWrite    = ctrl_q.ir_write & fetch_gate_s;
   assign AdrSrc     = ctrl_q.adr_src;
   assign MemWrite   = ctrl_q.mem_write;
   assign RegWrite   = ctrl_q.reg_write;
   assign ResultSrc  = ctrl_q.result_src;
   assign ALUSrcA    = ctrl_q.alu_src_a;
   assign ALUSrcB    = ctrl_q.alu_src_b;
   assign ALUControl = alu_control_q;
   assign Halted     = ctrl_q.halted;

   // Immediate format follows the opcode; forced to I-format while idle/in reset.
   always_comb begin
      ImmSrc = IMM_I;
      if (state_q == S_IDLE) begin
         ImmSrc = IMM_I;
      end else begin
         case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BR:   ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
         endcase
      end
   end

endmodule
